// File: rtl/vx_launch_ctrl.sv
// rtl/vx_launch_ctrl.sv - Vortex run sequencer: reset hold, launch, run, memory drain, done
module vx_launch_ctrl #(
  parameter int          ADDR_WIDTH       = 32,
  parameter int          DATA_WIDTH       = 32,
  parameter logic [31:0] PC_RESET_DEFAULT = 32'hF000_0000,
  parameter int          RESET_CYCLES     = 8,
  parameter int          BUSY_TIMEOUT     = 1024,
  parameter int          OUTST_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wen,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error,
  output logic                    request_stall,
  input  logic                    Vortex_busy,
  input  logic                    mem_req_fire,
  input  logic                    mem_req_rw,
  input  logic                    mem_rsp_fire,
  output logic                    Vortex_reset,
  output logic [31:0]             Vortex_PC_reset_val,
  output logic                    done_irq
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  logic [2:0]             state;
  logic                   done_flag;
  logic                   timeout_flag;
  logic [31:0]            pc;
  logic [DATA_WIDTH-1:0]  cycle_count;
  logic [OUTST_WIDTH-1:0] outstanding;
  logic [OUTST_WIDTH-1:0] outst_next;
  logic [RST_W-1:0]       rst_cnt;
  logic [TO_W-1:0]        launch_cnt;

  logic [2:0] idx;
  logic       unmapped;
  logic       wr_ok;
  logic       start_go;
  logic       abort_go;
  logic       w1c;
  logic       pc_wr;
  logic       unused_addr_bits;

  assign idx              = addr[4:2];
  assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:5], addr[1:0]};
  assign unmapped         = (idx > 3'd4);

  // Writes that are refused still complete in zero wait states; they are just dropped.
  assign error = ((wen | ren) & unmapped)
               | (wen & (idx == 3'd1 || idx == 3'd2) & (state != S_IDLE))
               | (wen & (idx == 3'd3));
  assign wr_ok    = wen & ~error;
  assign start_go = wr_ok & (idx == 3'd1) & wdata[0];
  assign abort_go = wr_ok & (idx == 3'd4) & wdata[0] & (state != S_IDLE);
  assign w1c      = wr_ok & (idx == 3'd0) & strobe[0];
  assign pc_wr    = wr_ok & (idx == 3'd2);

  assign request_stall       = 1'b0;
  assign Vortex_reset        = (state == S_IDLE) || (state == S_RESET);
  assign Vortex_PC_reset_val = pc;

  always_comb begin
    outst_next = outstanding;
    if ((mem_req_fire & ~mem_req_rw) & ~mem_rsp_fire) begin
      if (outstanding != '1) outst_next = outstanding + 1'b1;
    end else if (mem_rsp_fire & ~(mem_req_fire & ~mem_req_rw)) begin
      if (outstanding != '0) outst_next = outstanding - 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (ren) begin
      case (idx)
        3'd0:    rdata = DATA_WIDTH'({state, 1'b0, timeout_flag, done_flag, state != S_IDLE});
        3'd2:    rdata = DATA_WIDTH'(pc);
        3'd3:    rdata = cycle_count;
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      pc           <= PC_RESET_DEFAULT;
      cycle_count  <= '0;
      outstanding  <= '0;
      rst_cnt      <= '0;
      launch_cnt   <= '0;
      done_irq     <= 1'b0;
    end else begin
      done_irq    <= 1'b0;
      outstanding <= outst_next;
      if (pc_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (strobe[i]) pc[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (w1c) begin
        if (wdata[1]) done_flag    <= 1'b0;
        if (wdata[2]) timeout_flag <= 1'b0;
      end
      // FSM updates come after W1C so a same-cycle hardware set wins.
      if (abort_go) begin
        state       <= S_IDLE;
        outstanding <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_go) begin
              state        <= S_RESET;
              rst_cnt      <= '0;
              cycle_count  <= '0;
              done_flag    <= 1'b0;
              timeout_flag <= 1'b0;
            end
          end
          S_RESET: begin
            if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
              state      <= S_LAUNCH;
              launch_cnt <= '0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_LAUNCH: begin
            if (Vortex_busy) begin
              state <= S_RUN;
            end else if (launch_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
              state        <= S_IDLE;
              timeout_flag <= 1'b1;
              done_irq     <= 1'b1;
            end else begin
              launch_cnt <= launch_cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (!Vortex_busy) state <= S_DRAIN;
          end
          S_DRAIN: begin
            // Look at the post-update count so a final response this cycle finishes the drain.
            if (Vortex_busy) begin
              state <= S_RUN;
            end else if (outst_next == '0) begin
              state     <= S_IDLE;
              done_flag <= 1'b1;
              done_irq  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vx_launch_ctrl.sv
// tb/tb_vx_launch_ctrl.sv - self-checking bench for vx_launch_ctrl
module tb_vx_launch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen, ren;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        error, request_stall;
  logic        Vortex_busy, mem_req_fire, mem_req_rw, mem_rsp_fire;
  logic        Vortex_reset;
  logic [31:0] Vortex_PC_reset_val;
  logic        done_irq;

  always #5 clk = ~clk;

  vx_launch_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_RESET_DEFAULT(32'hF000_0000),
    .RESET_CYCLES(8), .BUSY_TIMEOUT(16), .OUTST_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
    .strobe(strobe), .rdata(rdata), .error(error), .request_stall(request_stall),
    .Vortex_busy(Vortex_busy), .mem_req_fire(mem_req_fire), .mem_req_rw(mem_req_rw),
    .mem_rsp_fire(mem_rsp_fire), .Vortex_reset(Vortex_reset),
    .Vortex_PC_reset_val(Vortex_PC_reset_val), .done_irq(done_irq)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] er;
    logic        ee;
  } vec_t;
  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one register access for a cycle; expectation queued at drive, compared at negedge.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] er, input logic ee, input string nm);
    exp_t e;
    wen = w; ren = r; addr = a; wdata = d; strobe = s;
    e.rdata = er; e.err = ee; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, " rdata"}, rdata, e.rdata);
    check({e.name, " error"}, {31'd0, error}, {31'd0, e.err});
    tick();
    wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; strobe = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er, input string nm);
    access(1'b0, 1'b1, a, 32'd0, 4'h0, er, 1'b0, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic ee, input string nm);
    access(1'b1, 1'b0, a, d, s, 32'd0, ee, nm);
  endtask

  // Starting at the current cycle (index 0), watch done_irq for n cycles.
  task automatic watch_irq(input int n, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_irq) begin
        cnt++;
        if (first < 0) first = i;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt, irq_n, irq_at, n, bad;
    logic seen;

    vt[0]  = '{1'b0, 1'b1, 32'h00, 32'h0,         4'h0, 32'h0,         1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h08, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h08, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h08, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h08, 32'h0,         4'h0, 32'h12BB_56DD, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h0C, 32'h1,         4'hF, 32'h0,         1'b1};
    vt[6]  = '{1'b0, 1'b1, 32'h14, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[7]  = '{1'b0, 1'b1, 32'h18, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'h1C, 32'h1,         4'hF, 32'h0,         1'b1};
    vt[9]  = '{1'b0, 1'b1, 32'h04, 32'h0,         4'h0, 32'h0,         1'b0};
    vt[10] = '{1'b0, 1'b1, 32'h10, 32'h0,         4'h0, 32'h0,         1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h10, 32'h1,         4'hF, 32'h0,         1'b0};
    vt[12] = '{1'b0, 1'b1, 32'h00, 32'h0,         4'h0, 32'h0,         1'b0};
    vt[13] = '{1'b0, 1'b1, 32'h0C, 32'h0,         4'h0, 32'h0,         1'b0};
    vt[14] = '{1'b1, 1'b0, 32'h08, 32'h8000_0000, 4'hF, 32'h0,         1'b0};
    vt[15] = '{1'b0, 1'b1, 32'h08, 32'h0,         4'h0, 32'h8000_0000, 1'b0};
    vt[16] = '{1'b0, 1'b1, 32'h0B, 32'h0,         4'h0, 32'h8000_0000, 1'b0};

    reset = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; strobe = '0;
    Vortex_busy = 1'b0; mem_req_fire = 1'b0; mem_req_rw = 1'b0; mem_rsp_fire = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst Vortex_reset", {31'd0, Vortex_reset}, 32'd1);
    check("rst PC", Vortex_PC_reset_val, 32'hF000_0000);
    check("rst done_irq", {31'd0, done_irq}, 32'd0);
    check("rst error", {31'd0, error}, 32'd0);
    check("rst request_stall", {31'd0, request_stall}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    tick();
    rd(32'h00, 32'h0, "rst STATUS");

    // Register map vectors in IDLE
    for (int i = 0; i < 17; i++)
      access(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].s, vt[i].er, vt[i].ee, $sformatf("vec%0d", i));
    check("pc out", Vortex_PC_reset_val, 32'h8000_0000);

    // Normal run: 8 reset cycles, 50 run cycles, no reads
    wr(32'h04, 32'h1, 4'hF, 1'b0, "run start");
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Vortex_reset) hi_cnt++;
      tick();
    end
    check("run reset hold cycles", hi_cnt, 8);
    @(negedge clk);
    check("run Vortex_reset fall", {31'd0, Vortex_reset}, 32'd0);
    tick();
    rd(32'h00, 32'h21, "run STATUS launch");
    Vortex_busy = 1'b1;
    repeat (50) tick();
    Vortex_busy = 1'b0;
    watch_irq(8, irq_n, irq_at);
    check("run irq count", irq_n, 1);
    check("run irq cycle", irq_at, 2);
    rd(32'h0C, 32'd50, "run CYCLE_COUNT");
    rd(32'h00, 32'h02, "run STATUS done");
    check("run Vortex_reset idle", {31'd0, Vortex_reset}, 32'd1);

    // Drain: 3 reads, 1 response before busy falls, req+rsp same cycle, write req, 2 late responses
    wr(32'h04, 32'h1, 4'hF, 1'b0, "drain start");
    Vortex_busy = 1'b1;
    repeat (14) tick();
    mem_req_fire = 1'b1; mem_req_rw = 1'b0;
    repeat (3) tick();
    mem_req_fire = 1'b0;
    mem_rsp_fire = 1'b1;
    tick();
    mem_rsp_fire = 1'b0;
    Vortex_busy = 1'b0;
    tick();
    mem_req_fire = 1'b1; mem_req_rw = 1'b0; mem_rsp_fire = 1'b1;
    tick();
    mem_rsp_fire = 1'b0; mem_req_rw = 1'b1;
    tick();
    mem_req_fire = 1'b0; mem_req_rw = 1'b0;
    ren = 1'b1; addr = 32'h00;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdata !== 32'h41 || done_irq !== 1'b0) bad++;
      tick();
    end
    check("drain held cycles bad", bad, 0);
    mem_rsp_fire = 1'b1;
    @(negedge clk);
    check("drain STATUS rsp1", rdata, 32'h41);
    tick();
    @(negedge clk);
    check("drain STATUS rsp2", rdata, 32'h41);
    check("drain irq early", {31'd0, done_irq}, 32'd0);
    tick();
    mem_rsp_fire = 1'b0;
    @(negedge clk);
    check("drain irq", {31'd0, done_irq}, 32'd1);
    check("drain STATUS done", rdata, 32'h02);
    tick();
    @(negedge clk);
    check("drain irq one cycle", {31'd0, done_irq}, 32'd0);
    tick();
    ren = 1'b0;

    // Timeout: busy never rises
    wr(32'h04, 32'h1, 4'hF, 1'b0, "to start");
    n = 0; seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      if (done_irq) begin
        seen = 1'b1;
        check("to Vortex_reset at irq", {31'd0, Vortex_reset}, 32'd1);
      end
      tick();
      if (!seen) n++;
    end
    check("to cycles to irq", n, 24);
    rd(32'h00, 32'h04, "to STATUS");
    wr(32'h00, 32'h04, 4'h0, 1'b0, "to w1c nostrobe");
    rd(32'h00, 32'h04, "to STATUS kept");
    wr(32'h00, 32'h04, 4'h1, 1'b0, "to w1c");
    rd(32'h00, 32'h00, "to STATUS clear");

    // Illegal accesses and abort in RUN with 2 outstanding
    wr(32'h04, 32'h1, 4'hF, 1'b0, "ab start");
    Vortex_busy = 1'b1;
    repeat (14) tick();
    mem_req_fire = 1'b1; mem_req_rw = 1'b0;
    repeat (2) tick();
    mem_req_fire = 1'b0;
    wr(32'h08, 32'h1111_1111, 4'hF, 1'b1, "ill PC wr run");
    wr(32'h04, 32'h1, 4'hF, 1'b1, "ill START run");
    access(1'b0, 1'b1, 32'h14, 32'h0, 4'h0, 32'h0, 1'b1, "ill rd 0x14");
    rd(32'h08, 32'h8000_0000, "ill PC unchanged");
    rd(32'h00, 32'h31, "ab STATUS run");
    wr(32'h10, 32'h1, 4'hF, 1'b0, "ab abort");
    @(negedge clk);
    check("ab Vortex_reset", {31'd0, Vortex_reset}, 32'd1);
    tick();
    rd(32'h00, 32'h00, "ab STATUS idle");
    Vortex_busy = 1'b0;
    watch_irq(5, irq_n, irq_at);
    check("ab no irq", irq_n, 0);

    // Outstanding count was cleared by abort: next run ends without responses
    wr(32'h04, 32'h1, 4'hF, 1'b0, "ab2 start");
    Vortex_busy = 1'b1;
    repeat (14) tick();
    Vortex_busy = 1'b0;
    watch_irq(8, irq_n, irq_at);
    check("ab2 irq count", irq_n, 1);
    check("ab2 irq cycle", irq_at, 2);

    // Reset overrides a same-cycle register write
    reset = 1'b1; wen = 1'b1; addr = 32'h08; wdata = 32'h5555_5555; strobe = 4'hF;
    tick();
    reset = 1'b0; wen = 1'b0; addr = '0; wdata = '0; strobe = '0;
    rd(32'h08, 32'hF000_0000, "rst over write PC");
    rd(32'h00, 32'h00, "rst over write STATUS");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
